// File: rtl/slc3_mem_bridge_if.sv
// slc3_mem_bridge_if: bundles the CPU request/ready handshake, the SRAM pins and the
// board I/O (switches, hex nibbles, LEDs) seen by slc3_mem_bridge.
//   slave  modport : the bridge side (takes CPU requests, drives SRAM pins and board outputs)
//   master modport : the CPU/board/SRAM model side (drives requests, SRAM read data, switches)
interface slc3_mem_bridge_if #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned SW_W       = 10,
    parameter int unsigned HEX_DIGITS = 4,
    parameter int unsigned LED_W      = 10
);
    // CPU handshake
    logic                    cpu_req;
    logic                    cpu_we;
    logic [ADDR_W-1:0]       cpu_addr;
    logic [DATA_W-1:0]       cpu_wdata;
    logic                    cpu_ready;
    logic [DATA_W-1:0]       cpu_rdata;
    // SRAM pins
    logic [ADDR_W-1:0]       sram_addr;
    logic [DATA_W-1:0]       sram_wdata;
    logic [DATA_W-1:0]       sram_rdata;
    logic                    sram_oe_n;
    logic                    sram_we_n;
    // Board I/O
    logic [SW_W-1:0]         SW;
    logic [HEX_DIGITS*4-1:0] hex_data;
    logic [LED_W-1:0]        led;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_rdata, SW,
        output cpu_ready, cpu_rdata, sram_addr, sram_wdata, sram_oe_n, sram_we_n,
        output hex_data, led
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_rdata, SW,
        input  cpu_ready, cpu_rdata, sram_addr, sram_wdata, sram_oe_n, sram_we_n,
        input  hex_data, led
    );
endinterface

// File: rtl/slc3_mem_bridge.sv
// slc3_mem_bridge: request/ready bridge between the SLC-3 datapath and SRAM plus
// memory-mapped switches / hex display / LEDs.
//   Clk   : system clock, rising edge
//   Reset : synchronous active-low reset
//   bus   : slc3_mem_bridge_if.slave -- CPU handshake (cpu_req/we/addr/wdata in,
//           cpu_ready pulse and held cpu_rdata out), registered SRAM address/data/strobes,
//           switches in, hex nibbles and LED register out.
// An access to IO_ADDR is served in one IO cycle without touching SRAM; SRAM accesses hold
// their strobe for WAIT_STATES+1 cycles. Completion is a one-cycle cpu_ready in DONE.
// Optional feature macro SLC3_LED_REG_EN: when defined, IO_ADDR-1 is a read/write LED
// register; when undefined, led is tied low and IO_ADDR-1 is ordinary SRAM.
module slc3_mem_bridge #(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR     = 16'hFFFF,
    parameter int unsigned       SW_W        = 10,
    parameter int unsigned       HEX_DIGITS  = 4,
    parameter int unsigned       LED_W       = 10
) (
    input logic             Clk,
    input logic             Reset,
    slc3_mem_bridge_if.slave bus
);
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StIo     = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    // Counter must be at least one bit wide even when WAIT_STATES is 0.
    localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    logic [1:0]              state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    oe_n_q, oe_n_d;
    logic                    we_n_q, we_n_d;
    logic [HEX_DIGITS*4-1:0] hex_q, hex_d;
    logic                    is_io;

`ifdef SLC3_LED_REG_EN
    localparam logic [ADDR_W-1:0] LedAddr = ADDR_W'(IO_ADDR - 1);
    logic [LED_W-1:0] led_q, led_d;

    assign is_io = (bus.cpu_addr == IO_ADDR) || (bus.cpu_addr == LedAddr);
`else
    assign is_io = (bus.cpu_addr == IO_ADDR);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        hex_d   = hex_q;
`ifdef SLC3_LED_REG_EN
        led_d   = led_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    we_d    = bus.cpu_we;
                    if (is_io) begin
                        state_d = StIo;
                    end else begin
                        // Strobe is registered so it is asserted from the first ACCESS cycle.
                        state_d = StAccess;
                        cnt_d   = CntW'(WAIT_STATES);
                        oe_n_d  = bus.cpu_we;
                        we_n_d  = ~bus.cpu_we;
                    end
                end
            end
            StAccess: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    if (!we_q) begin
                        rdata_d = bus.sram_rdata;
                    end
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StIo: begin
                if (addr_q == IO_ADDR) begin
                    if (we_q) begin
                        hex_d = wdata_q[HEX_DIGITS*4-1:0];
                    end else begin
                        rdata_d = DATA_W'(bus.SW);
                    end
                end
`ifdef SLC3_LED_REG_EN
                else if (addr_q == LedAddr) begin
                    if (we_q) begin
                        led_d = wdata_q[LED_W-1:0];
                    end else begin
                        rdata_d = DATA_W'(led_q);
                    end
                end
`endif
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            hex_q   <= '0;
`ifdef SLC3_LED_REG_EN
            led_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            hex_q   <= hex_d;
`ifdef SLC3_LED_REG_EN
            led_q   <= led_d;
`endif
        end
    end

    assign bus.cpu_ready  = (state_q == StDone);
    assign bus.cpu_rdata  = rdata_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.sram_oe_n  = oe_n_q;
    assign bus.sram_we_n  = we_n_q;
    assign bus.hex_data   = hex_q;
`ifdef SLC3_LED_REG_EN
    assign bus.led        = led_q;
`else
    assign bus.led        = {LED_W{1'b0}};
`endif
endmodule

// File: tb/tb_slc3_mem_bridge.sv
// Directed bench: u_dut runs with WAIT_STATES=2, u_dut0 with WAIT_STATES=0.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point, so after
// the tick that samples a request the bench sits in "cycle 1" of the transaction.
module tb_slc3_mem_bridge;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    slc3_mem_bridge_if #(.ADDR_W(16), .DATA_W(16), .SW_W(10), .HEX_DIGITS(4), .LED_W(10)) bus ();
    slc3_mem_bridge_if #(.ADDR_W(16), .DATA_W(16), .SW_W(10), .HEX_DIGITS(4), .LED_W(10)) bus0 ();

    slc3_mem_bridge #(.WAIT_STATES(2)) u_dut (.Clk(clk), .Reset(rst_n), .bus(bus));
    slc3_mem_bridge #(.WAIT_STATES(0)) u_dut0 (.Clk(clk), .Reset(rst_n), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        // Not a shared helper for expectations: only formats the comparison result.
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic req(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        tick();
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_ready", {31'd0, bus.cpu_ready}, 32'd0);
        chk("rst_rdata", {16'd0, bus.cpu_rdata}, 32'd0);
        chk("rst_oe_we", {30'd0, bus.sram_oe_n, bus.sram_we_n}, 32'd3);
        chk("rst_addr_wdata", {bus.sram_addr, bus.sram_wdata}, 32'd0);
        chk("rst_hex_led", {bus.hex_data, 6'd0, bus.led}, 32'd0);
        chk("rst0_oe_we_ready", {29'd0, bus0.sram_oe_n, bus0.sram_we_n, bus0.cpu_ready}, 32'd6);
    endtask

    task automatic test_reset_mid_write();
        int seen_ready;
        req(1'b1, 16'h0200, 16'hAAAA);
        chk("midw_we_low", {31'd0, bus.sram_we_n}, 32'd0);
        rst_n = 1'b0;
        tick();
        chk("midw_we_abort", {31'd0, bus.sram_we_n}, 32'd1);
        chk("midw_ready_abort", {31'd0, bus.cpu_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        chk("midw_addr_wdata", {bus.sram_addr, bus.sram_wdata}, 32'd0);
        chk("midw_rdata_hex", {bus.cpu_rdata, bus.hex_data}, 32'd0);
        seen_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.cpu_ready === 1'b1) seen_ready++;
        end
        chk("midw_no_ready", seen_ready, 0);
    endtask

    task automatic test_sram_read();
        bus.sram_rdata = 16'hBEEF;
        req(1'b0, 16'h3000, 16'h0000);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("rd_oe_c%0d", c), {30'd0, bus.sram_oe_n, bus.cpu_ready}, 32'd0);
            chk($sformatf("rd_addr_c%0d", c), {16'd0, bus.sram_addr}, 32'h3000);
            tick();
        end
        chk("rd_ready_c4", {31'd0, bus.cpu_ready}, 32'd1);
        chk("rd_oe_c4", {31'd0, bus.sram_oe_n}, 32'd1);
        chk("rd_rdata", {16'd0, bus.cpu_rdata}, 32'h0000BEEF);
        tick();
        chk("rd_ready_c5", {31'd0, bus.cpu_ready}, 32'd0);
    endtask

    task automatic test_sram_write_ws0();
        bus0.sram_rdata = 16'h5A5A;
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 16'h0010; bus0.cpu_wdata = 16'h0;
        tick();
        bus0.cpu_req = 1'b0;
        tick();
        chk("w0_pre_rdata", {16'd0, bus0.cpu_rdata}, 32'h5A5A);
        tick();
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1; bus0.cpu_addr = 16'h0040;
        bus0.cpu_wdata = 16'h1234;
        tick();
        bus0.cpu_req = 1'b0;
        chk("w0_c1_we_oe_ready", {29'd0, bus0.sram_we_n, bus0.sram_oe_n, bus0.cpu_ready},
            32'd2);
        chk("w0_c1_addr_data", {bus0.sram_addr, bus0.sram_wdata}, 32'h0040_1234);
        tick();
        chk("w0_c2_ready_we", {30'd0, bus0.cpu_ready, bus0.sram_we_n}, 32'd3);
        chk("w0_rdata_kept", {16'd0, bus0.cpu_rdata}, 32'h5A5A);
        chk("w0_addr_hold", {bus0.sram_addr, bus0.sram_wdata}, 32'h0040_1234);
        tick();
        chk("w0_c3_ready", {31'd0, bus0.cpu_ready}, 32'd0);
    endtask

    task automatic test_io_read();
        bus.SW = 10'h2A5;
        req(1'b0, 16'hFFFF, 16'h0000);
        chk("io_c1_strobes", {29'd0, bus.sram_oe_n, bus.sram_we_n, bus.cpu_ready}, 32'd6);
        tick();
        chk("io_c2_ready_strobes", {29'd0, bus.sram_oe_n, bus.sram_we_n, bus.cpu_ready},
            32'd7);
        chk("io_rdata", {16'd0, bus.cpu_rdata}, 32'h02A5);
        tick();
    endtask

    task automatic test_hex_write();
        int we_low;
        req(1'b1, 16'hFFFF, 16'hC0DE);
        chk("hex_c1_we", {31'd0, bus.sram_we_n}, 32'd1);
        tick();
        chk("hex_c2_ready", {31'd0, bus.cpu_ready}, 32'd1);
        chk("hex_value", {16'd0, bus.hex_data}, 32'hC0DE);
        tick();
        req(1'b1, 16'h0100, 16'h5555);
        we_low = 0;
        for (int c = 1; c <= 3; c++) begin
            if (bus.sram_we_n === 1'b0) we_low++;
            tick();
        end
        chk("sw_we_cycles", we_low, 3);
        chk("sw_ready_c4", {31'd0, bus.cpu_ready}, 32'd1);
        chk("hex_after_sram", {16'd0, bus.hex_data}, 32'hC0DE);
        chk("rdata_after_writes", {16'd0, bus.cpu_rdata}, 32'h02A5);
        tick();
    endtask

    task automatic test_led();
        req(1'b1, 16'hFFFE, 16'h03FF);
`ifdef SLC3_LED_REG_EN
        chk("led_c1_we", {31'd0, bus.sram_we_n}, 32'd1);
        tick();
        chk("led_c2_ready", {31'd0, bus.cpu_ready}, 32'd1);
        chk("led_value", {22'd0, bus.led}, 32'h3FF);
        tick();
        req(1'b0, 16'hFFFE, 16'h0000);
        tick();
        chk("led_rd_ready", {31'd0, bus.cpu_ready}, 32'd1);
        chk("led_rdata", {16'd0, bus.cpu_rdata}, 32'h03FF);
`else
        chk("led_c1_sram_we", {31'd0, bus.sram_we_n}, 32'd0);
        tick();
        tick();
        tick();
        chk("led_c4_ready", {31'd0, bus.cpu_ready}, 32'd1);
        chk("led_tied0", {22'd0, bus.led}, 32'd0);
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        bus0.sram_rdata = 16'h1111;
        bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 16'h3000; bus0.cpu_wdata = 16'h0;
        tick();
        chk("b2b_c1_oe", {31'd0, bus0.sram_oe_n}, 32'd0);
        tick();
        chk("b2b_c2_ready", {31'd0, bus0.cpu_ready}, 32'd1);
        chk("b2b_c2_rdata", {16'd0, bus0.cpu_rdata}, 32'h1111);
        bus0.sram_rdata = 16'h2222;
        tick();
        chk("b2b_c3_idle", {29'd0, bus0.cpu_ready, bus0.sram_oe_n, bus0.sram_we_n}, 32'd3);
        tick();
        chk("b2b_c4_oe", {31'd0, bus0.sram_oe_n}, 32'd0);
        bus0.cpu_req = 1'b0;
        tick();
        chk("b2b_c5_ready", {31'd0, bus0.cpu_ready}, 32'd1);
        chk("b2b_c5_rdata", {16'd0, bus0.cpu_rdata}, 32'h2222);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_addr = '0;  bus.cpu_wdata = '0;
        bus.sram_rdata = '0; bus.SW = '0;
        bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
        bus0.sram_rdata = '0; bus0.SW = '0;
        rst_n = 1'b0;
        test_reset();
        test_reset_mid_write();
        test_sram_read();
        test_sram_write_ws0();
        test_io_read();
        test_hex_write();
        test_led();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/slc3_mem_bridge.md
Name: slc3_mem_bridge

Overview:
- Parametrised memory/IO bridge between the SLC-3 datapath and physical SRAM plus memory-mapped switches, hex and LEDs.
- Next generation of the CPU-to-memory path: replaces fixed-timing OE/WE control with a request/ready handshake and configurable SRAM wait states.
- Sits between the datapath MAR/MDR and the SRAM pins, beside the ISDU, which waits on cpu_ready.

Parameters:
ADDR_W, 16, CPU/SRAM address width
DATA_W, 16, data width
WAIT_STATES, 2, extra SRAM cycles per access (0 legal)
IO_ADDR, 16'hFFFF, switch-read / hex-write address
SW_W, 10, switch width (SW_W <= DATA_W)
HEX_DIGITS, 4, hex nibbles held (HEX_DIGITS*4 <= DATA_W)
LED_W, 10, LED register width (used only with the optional feature)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low reset
cpu_req  in  1  access request, sampled in IDLE
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  access address
cpu_wdata  in  DATA_W  write data
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read result, held until next read completes
sram_addr  out  ADDR_W  registered SRAM address
sram_wdata  out  DATA_W  registered SRAM write data
sram_rdata  in  DATA_W  SRAM read data
sram_oe_n  out  1  SRAM output enable, active low
sram_we_n  out  1  SRAM write enable, active low
SW  in  SW_W  board switches
hex_data  out  HEX_DIGITS*4  raw hex nibbles; segment decode is external
led  out  LED_W  LED register

Behaviour:
- Reset low at a rising edge forces the following:
  - state = IDLE, wait counter = 0, cpu_ready = 0, cpu_rdata = 0.
  - sram_oe_n = sram_we_n = 1, sram_addr = sram_wdata = 0.
  - hex_data = 0, led = 0.
- Reset mid-access aborts the access: strobes deassert at that edge and no cpu_ready is issued.
- States are IDLE, ACCESS, IO, DONE.
- IDLE:
  - Strobes high, cpu_ready 0.
  - When cpu_req = 1, latch cpu_addr/cpu_we/cpu_wdata into sram_addr/we flag/sram_wdata.
  - If the address matches the IO map, go to IO; otherwise go to ACCESS with counter = WAIT_STATES.
- ACCESS:
  - Read drives sram_oe_n = 0; write drives sram_we_n = 0. Address and data are stable for the whole state.
  - While counter != 0, decrement and stay.
  - When counter == 0, a read captures sram_rdata into cpu_rdata, strobes deassert, and the state goes to DONE.
  - ACCESS lasts exactly WAIT_STATES+1 cycles.
- IO (one cycle, strobes stay high):
  - Read at IO_ADDR: cpu_rdata = zero-extended SW.
  - Write at IO_ADDR: hex_data = wdata[HEX_DIGITS*4-1:0].
  - Next state is DONE.
- DONE:
  - cpu_ready = 1 for exactly one cycle; next state is IDLE.
  - cpu_req is ignored in ACCESS/IO/DONE.
- Latency is counted from the edge that samples the request in IDLE:
  - SRAM: cpu_ready is high in cycle WAIT_STATES+2.
  - IO: cpu_ready is high in cycle 2.
- cpu_req held high continuously gives back-to-back transactions, one IDLE cycle between them.
- sram_addr/sram_wdata hold their last value after an access; they change only on request acceptance.
- A write never alters cpu_rdata.
- IO addresses never assert an SRAM strobe; SRAM writes never alter hex_data/led.

Optional Feature:
- Macro: SLC3_LED_REG_EN.
- Defined:
  - Address IO_ADDR-1 is the LED register and is handled in the IO state.
  - Write: led = wdata[LED_W-1:0].
  - Read: cpu_rdata = zero-extended led.
- Undefined:
  - led is tied 0.
  - IO_ADDR-1 is an ordinary SRAM address.

Test Plan:
1. Reset low 2 cycles mid-write (sram_we_n = 0) -> sram_we_n = 1 at that edge, no cpu_ready; all outputs at reset values.
2. WAIT_STATES = 2, read 0x3000, SRAM returns 0xBEEF -> sram_oe_n low 3 cycles; cpu_ready pulses at cycle 4; cpu_rdata = 0xBEEF.
3. WAIT_STATES = 0, write 0x1234 to 0x0040 -> sram_we_n low exactly 1 cycle with addr 0x0040 / data 0x1234 stable; cpu_ready at cycle 2; cpu_rdata unchanged.
4. SW = 10'h2A5, read 0xFFFF -> no SRAM strobe; cpu_rdata = 0x02A5 at cycle 2.
5. Write 0xC0DE to 0xFFFF, then write 0x5555 to 0x0100 -> hex_data = 0xC0DE and stays 0xC0DE after the SRAM write.
6. SLC3_LED_REG_EN defined, write 0x03FF to 0xFFFE then read it back -> led = 10'h3FF, cpu_rdata = 0x03FF. Undefined: same write is an SRAM write and led stays 0.
